// File: rtl/dct_pkg.sv
// Shared constants, read-FSM encoding and window packing helpers for the dct block family.
// Purely declarative; no state, no handshake.
package dct_pkg;
    localparam int BLK       = 8;
    localparam int BLK_ELEMS = BLK * BLK;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    // Element k = r*BLK + c sits at bit offset k*n of a flattened window, element 0 in the LSBs.
    function automatic int elem_index(input int r, input int c);
        return r * BLK + c;
    endfunction

    function automatic int elem_offset(input int k, input int n);
        return k * n;
    endfunction
endpackage

// File: rtl/dct_strip_bank.sv
// One strip of 8 rows x IMG_W samples: whole-window writes, single-sample combinational reads.
// Write lands on the clock edge; no flow control of its own.
module dct_strip_bank
    import dct_pkg::*;
#(
    parameter int N     = 10,
    parameter int IMG_W = 128,
    localparam int NBC  = IMG_W / BLK,
    localparam int BCW  = (NBC > 1) ? $clog2(NBC) : 1,
    localparam int CW   = $clog2(IMG_W)
)(
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [BCW-1:0]         wr_bc,
    input  logic [N*BLK_ELEMS-1:0] wr_data,
    input  logic [2:0]             rd_row,
    input  logic [CW-1:0]          rd_col,
    output logic [N-1:0]           rd_data
);
    // Stored window-per-entry so the write is a single full-width store.
    logic [N*BLK_ELEMS-1:0] mem [NBC];
    logic [N*BLK_ELEMS-1:0] rd_win;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bc] <= wr_data;
        end
    end

    always_comb begin
        rd_win  = mem[rd_col[CW-1:3]];
        rd_data = rd_win[elem_offset(elem_index(int'(rd_row), int'(rd_col[2:0])), N) +: N];
    end
endmodule

// File: rtl/dct_block_untiler.sv
// Reassembles 8x8 windows into raster-order pixels through two ping-pong strip banks.
// First pixel is valid 2 edges after a strip's last window; windows stall while both banks are full.
module dct_block_untiler
    import dct_pkg::*;
#(
    parameter int N     = 10,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic [N*BLK_ELEMS-1:0]   blk_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [N-1:0]             pix_data,
    output logic [$clog2(IMG_H)-1:0] pix_row,
    output logic [$clog2(IMG_W)-1:0] pix_col,
    output logic                     pix_last
);
    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W);
    localparam int NBC = IMG_W / BLK;
    localparam int NS  = IMG_H / BLK;
    localparam int BCW = (NBC > 1) ? $clog2(NBC) : 1;
    localparam int SW  = (NS > 1) ? $clog2(NS) : 1;

    logic [1:0]     full;
    logic [1:0]     full_set;
    logic [1:0]     full_clr;
    logic           wbank;
    logic           rbank;
    logic           src_bank;
    logic [BCW-1:0] bc;
    rd_state_t      state;
    logic [2:0]     rd_r;
    logic [CW-1:0]  rd_c;
    logic [SW-1:0]  strip;
    logic [N-1:0]   bank0_dat;
    logic [N-1:0]   bank1_dat;
    logic           accept;
    logic           xfer;
    logic           can_load;
    logic           rd_end;
    logic           strip_end;

    assign blk_ready = !full[wbank];
    assign accept    = blk_valid && blk_ready;
    assign xfer      = pix_valid && pix_ready;
    assign can_load  = (state == RD_STREAM) && (!pix_valid || pix_ready);
    assign rd_end    = (rd_r == 3'd7) && (rd_c == CW'(IMG_W - 1));
    assign strip_end = (strip == SW'(NS - 1));

    // A bank is released only once its final sample has left the output register.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (accept && (bc == BCW'(NBC - 1))) begin
            full_set[wbank] = 1'b1;
        end
        if (xfer && (pix_row[2:0] == 3'd7) && (pix_col == CW'(IMG_W - 1))) begin
            full_clr[src_bank] = 1'b1;
        end
    end

    dct_strip_bank #(.N(N), .IMG_W(IMG_W)) u_bank0 (
        .clk     (clk),
        .wr_en   (accept && !wbank),
        .wr_bc   (bc),
        .wr_data (blk_data),
        .rd_row  (rd_r),
        .rd_col  (rd_c),
        .rd_data (bank0_dat)
    );

    dct_strip_bank #(.N(N), .IMG_W(IMG_W)) u_bank1 (
        .clk     (clk),
        .wr_en   (accept && wbank),
        .wr_bc   (bc),
        .wr_data (blk_data),
        .rd_row  (rd_r),
        .rd_col  (rd_c),
        .rd_data (bank1_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank <= 1'b0;
            bc    <= '0;
            full  <= 2'b00;
        end else begin
            full <= (full & ~full_clr) | full_set;
            if (accept) begin
                if (bc == BCW'(NBC - 1)) begin
                    bc    <= '0;
                    wbank <= ~wbank;
                end else begin
                    bc <= bc + 1'b1;
                end
            end
        end
    end

    // The scan pointer runs one sample ahead of the output register, so the
    // next bank is picked up on the same edge the previous strip's last sample loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RD_IDLE;
            rbank     <= 1'b0;
            src_bank  <= 1'b0;
            rd_r      <= '0;
            rd_c      <= '0;
            strip     <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_row   <= '0;
            pix_col   <= '0;
            pix_last  <= 1'b0;
        end else begin
            if (can_load) begin
                pix_valid <= 1'b1;
                pix_data  <= rbank ? bank1_dat : bank0_dat;
                pix_row   <= RW'({strip, rd_r});
                pix_col   <= rd_c;
                pix_last  <= strip_end && rd_end;
                src_bank  <= rbank;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end

            case (state)
                RD_IDLE: begin
                    if (full[rbank]) begin
                        state <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (can_load) begin
                        if (rd_end) begin
                            rd_r  <= '0;
                            rd_c  <= '0;
                            rbank <= ~rbank;
                            strip <= strip_end ? '0 : strip + 1'b1;
                            state <= full[~rbank] ? RD_STREAM : RD_IDLE;
                        end else if (rd_c == CW'(IMG_W - 1)) begin
                            rd_c <= '0;
                            rd_r <= rd_r + 3'd1;
                        end else begin
                            rd_c <= rd_c + 1'b1;
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_block_untiler.sv
// Self-checking bench for dct_block_untiler: scenario table plus hand sequences, scored
// against a raster model built from the windows pushed in.
module tb_dct_block_untiler;
    localparam int N     = 10;
    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int NBC   = IMG_W / 8;
    localparam int NS    = IMG_H / 8;
    localparam int WW    = N * 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          blk_valid = 1'b0;
    logic          blk_ready;
    logic [WW-1:0] blk_data = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [N-1:0]  pix_data;
    logic [6:0]    pix_row;
    logic [6:0]    pix_col;
    logic          pix_last;

    dct_block_untiler #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_last  (pix_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        int           row;
        int           col;
        logic         last;
    } pix_t;

    typedef struct {
        int nwin;
        int pat;
        int rmode;
        int exp_pix;
        int exp_last;
    } vec_t;

    pix_t          exp_q[$];
    logic [WW-1:0] win_q[$];
    logic [WW-1:0] strip_buf [NBC];
    int fpos  = 0;
    int sent  = 0;
    int total = 0;
    int bad   = 0;
    int n_pix = 0;
    int n_last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: collect one strip of windows, then emit it in raster order.
    function automatic void model_push(input logic [WW-1:0] w);
        int s;
        s = (fpos / NBC) % NS;
        strip_buf[fpos % NBC] = w;
        if (fpos % NBC == NBC - 1) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    pix_t p;
                    logic [WW-1:0] cw;
                    cw = strip_buf[c / 8];
                    p.data = cw[(r * 8 + c % 8) * N +: N];
                    p.row  = s * 8 + r;
                    p.col  = c;
                    p.last = (p.row == IMG_H - 1) && (c == IMG_W - 1);
                    exp_q.push_back(p);
                end
            end
        end
        fpos = (fpos + 1) % (NBC * NS);
    endfunction

    function automatic logic [WW-1:0] make_win(input int pat, input int widx);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < 64; k++) begin
            logic [N-1:0] e;
            case (pat)
                0:       e = N'((widx % NBC) * 64 + k);
                1:       e = (k % 2 == 0) ? N'(-512) : N'(511);
                2:       e = N'($urandom);
                default: e = N'(341);
            endcase
            w[k * N +: N] = e;
        end
        return w;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {pix_valid, pix_data, pix_row, pix_col, pix_last}, '0);
        rst = 1'b0;
        #1;
        check("reset blk_ready", blk_ready, 1);
        fpos = 0;
        sent = 0;
        exp_q.delete();
        win_q.delete();
    endtask

    task automatic send_n(input int upto, input int max_cyc);
        int cyc;
        cyc = 0;
        while (sent < upto && cyc < max_cyc) begin
            @(negedge clk);
            blk_valid = 1'b1;
            blk_data  = win_q[sent];
            if (blk_ready) sent++;
            cyc++;
        end
    endtask

    // Feeds the rest of win_q and scores every pixel transfer, with a quiet tail at the end.
    task automatic run(input int rmode, input bit chk_rel, input int max_cyc);
        int cyc, idle;
        bit rel_seen, rel_pend, hold_pend;
        logic [N-1:0] hd;
        logic [6:0] hr, hc;
        pix_t e;
        cyc = 0; idle = 0; rel_seen = 0; rel_pend = 0; hold_pend = 0;
        hd = '0; hr = '0; hc = '0;
        n_pix = 0; n_last = 0;
        while ((sent < win_q.size() || exp_q.size() > 0 || idle < 20) && cyc < max_cyc) begin
            @(negedge clk);
            if (rel_pend) begin
                check("blk_ready after release", blk_ready, 1);
                rel_pend = 0;
            end
            if (hold_pend) check("stall hold", {pix_valid, pix_data, pix_row, pix_col}, {1'b1, hd, hr, hc});
            case (rmode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ((cyc / 3) % 2 == 0);
                2:       pix_ready = ($urandom_range(3) != 0);
                default: pix_ready = ($urandom_range(1) != 0);
            endcase
            blk_valid = (sent < win_q.size());
            blk_data  = blk_valid ? win_q[sent] : '0;
            hold_pend = pix_valid && !pix_ready;
            hd = pix_data; hr = pix_row; hc = pix_col;
            if (pix_valid && pix_ready) begin
                n_pix++;
                if (pix_last) n_last++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra pixel: got row=%0d col=%0d data=%0h, required none", pix_row, pix_col, pix_data);
                end else begin
                    e = exp_q.pop_front();
                    if (pix_data !== e.data || int'(pix_row) != e.row || int'(pix_col) != e.col || pix_last !== e.last) begin
                        bad++;
                        $display("FAIL pixel: got data=%0h row=%0d col=%0d last=%0b, required data=%0h row=%0d col=%0d last=%0b",
                                 pix_data, pix_row, pix_col, pix_last, e.data, e.row, e.col, e.last);
                    end
                end
                if (chk_rel && !rel_seen && pix_row[2:0] == 3'd7 && int'(pix_col) == IMG_W - 1) begin
                    check("blk_ready before release", blk_ready, 0);
                    rel_seen = 1;
                    rel_pend = 1;
                end
            end
            if (blk_valid && blk_ready) sent++;
            if (sent == win_q.size() && exp_q.size() == 0) idle++;
            cyc++;
        end
        @(negedge clk);
        blk_valid = 1'b0;
        pix_ready = 1'b0;
        if (cyc >= max_cyc) begin
            total++;
            bad++;
            $display("FAIL run timeout: got %0d cycles, %0d pixels still expected", cyc, exp_q.size());
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [WW-1:0] w;
        tbl[0] = '{16,  0, 0, 1024,  0};
        tbl[1] = '{16,  0, 1, 1024,  0};
        tbl[2] = '{16,  1, 0, 1024,  0};
        tbl[3] = '{32,  2, 3, 2048,  0};
        tbl[4] = '{272, 2, 2, 17408, 1};

        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int i = 0; i < tbl[t].nwin; i++) begin
                w = make_win(tbl[t].pat, i);
                win_q.push_back(w);
                model_push(w);
            end
            run(tbl[t].rmode, 0, 40000);
            check($sformatf("vec%0d pixel count", t), n_pix, tbl[t].exp_pix);
            check($sformatf("vec%0d last count", t), n_last, tbl[t].exp_last);
        end

        // First-pixel latency: valid on the 2nd edge after the strip's last window.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = make_win(0, i);
            win_q.push_back(w);
            model_push(w);
        end
        send_n(16, 100);
        check("latency windows sent", sent, 16);
        @(negedge clk);
        blk_valid = 1'b0;
        check("latency edge1", pix_valid, 0);
        @(negedge clk);
        check("latency edge2", pix_valid, 0);
        @(negedge clk);
        check("latency edge3", pix_valid, 1);
        run(0, 0, 4000);
        check("latency strip count", n_pix, 1024);

        // Backpressure: both banks fill, the 33rd window waits for bank 0 to drain.
        do_reset();
        for (int i = 0; i < 48; i++) begin
            w = make_win(2, i);
            win_q.push_back(w);
            model_push(w);
        end
        send_n(48, 120);
        check("windows before stall", sent, 32);
        check("blk_ready stalled", blk_ready, 0);
        check("first pixel waiting", pix_valid, 1);
        run(0, 1, 8000);
        check("backpressure pixel count", n_pix, 3072);

        // Reset mid-strip with a pixel held at the output.
        do_reset();
        for (int i = 0; i < 21; i++) win_q.push_back(make_win(3, i));
        pix_ready = 1'b0;
        send_n(21, 100);
        @(negedge clk);
        blk_valid = 1'b0;
        @(negedge clk);
        check("pre-reset pixel", {pix_valid, pix_data}, {1'b1, N'(341)});
        #2 rst = 1'b1;
        #1;
        check("async reset outputs", {pix_valid, pix_data, pix_row, pix_col, pix_last}, '0);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = make_win(0, i);
            win_q.push_back(w);
            model_push(w);
        end
        run(0, 0, 4000);
        check("post-reset pixel count", n_pix, 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
